// File: rtl/ram_bus_arbiter_if.sv
// Bus bundle between the per-core cache request lines, the arbiter and the RAM model.
// The slave modport is the arbiter's view; master is the cores/RAM side.
package ram_bus_arbiter_pkg;
   typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
endpackage

interface ram_bus_arbiter_if #(parameter int CPUS = 2);
   import ram_bus_arbiter_pkg::*;

   logic [CPUS-1:0]       iREN;
   logic [CPUS-1:0]       dREN;
   logic [CPUS-1:0]       dWEN;
   logic [CPUS-1:0][31:0] iaddr;
   logic [CPUS-1:0][31:0] daddr;
   logic [CPUS-1:0][31:0] dstore;
   logic [CPUS-1:0]       iwait;
   logic [CPUS-1:0]       dwait;
   logic [CPUS-1:0][31:0] iload;
   logic [CPUS-1:0][31:0] dload;
   logic                  ramREN;
   logic                  ramWEN;
   logic [31:0]           ramaddr;
   logic [31:0]           ramstore;
   logic [31:0]           ramload;
   ramstate_t             ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Shares one RAM port among the I/D ports of CPUS cores; grant held until RAM ACCESS.
// RAM_ARB_ROUND_ROBIN_EN selects round-robin core scan; otherwise fixed priority from core 0.
module ram_bus_arbiter
   import ram_bus_arbiter_pkg::*;
#(
   parameter int CPUS = 2
) (
   input  logic CLK,
   input  logic nRST,
   ram_bus_arbiter_if.slave bus
);
   localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

   typedef enum logic {IDLE, OWN} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] owner_core_q, owner_core_d;
   logic          owner_is_data_q, owner_is_data_d;
   logic          owner_is_write_q, owner_is_write_d;
   logic [IW-1:0] scan_start;
   logic          req_live, done, arb_found, own_wr;
   int            scan_idx;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   assign scan_start = rr_ptr_q;
`else
   assign scan_start = '0;
`endif

   // Owner's request as currently presented; a drop aborts the transaction.
   always_comb begin
      req_live = owner_is_data_q ? (bus.dREN[owner_core_q] | bus.dWEN[owner_core_q])
                                 : bus.iREN[owner_core_q];
      own_wr   = owner_is_data_q & owner_is_write_q;
      done     = (state_q == OWN) && req_live && (bus.ramstate == ACCESS);
   end

   always_comb begin
      bus.iwait    = '1;
      bus.dwait    = '1;
      bus.iload    = '0;
      bus.dload    = '0;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      if (state_q == OWN) begin
         bus.ramaddr  = owner_is_data_q ? bus.daddr[owner_core_q] : bus.iaddr[owner_core_q];
         bus.ramWEN   = own_wr & req_live;
         bus.ramREN   = ~own_wr & req_live;
         bus.ramstore = own_wr ? bus.dstore[owner_core_q] : '0;
         if (done) begin
            if (owner_is_data_q) begin
               bus.dwait[owner_core_q] = 1'b0;
               if (!owner_is_write_q) bus.dload[owner_core_q] = bus.ramload;
            end else begin
               bus.iwait[owner_core_q] = 1'b0;
               bus.iload[owner_core_q] = bus.ramload;
            end
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      owner_core_d     = owner_core_q;
      owner_is_data_d  = owner_is_data_q;
      owner_is_write_d = owner_is_write_q;
      arb_found        = 1'b0;
      scan_idx         = 0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      rr_ptr_d         = rr_ptr_q;
`endif
      case (state_q)
         IDLE: begin
            // First requesting core from scan_start wins; data beats fetch, write beats read.
            for (int k = 0; k < CPUS; k++) begin
               scan_idx = (int'(scan_start) + k) % CPUS;
               if (!arb_found && (bus.iREN[scan_idx] | bus.dREN[scan_idx] | bus.dWEN[scan_idx])) begin
                  arb_found        = 1'b1;
                  state_d          = OWN;
                  owner_core_d     = IW'(scan_idx);
                  owner_is_data_d  = bus.dREN[scan_idx] | bus.dWEN[scan_idx];
                  owner_is_write_d = bus.dWEN[scan_idx];
               end
            end
         end
         OWN: begin
            if (!req_live || done) state_d = IDLE;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            if (done) rr_ptr_d = IW'((int'(owner_core_q) + 1) % CPUS);
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q          <= IDLE;
         owner_core_q     <= '0;
         owner_is_data_q  <= 1'b0;
         owner_is_write_q <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         rr_ptr_q         <= '0;
`endif
      end else begin
         state_q          <= state_d;
         owner_core_q     <= owner_core_d;
         owner_is_data_q  <= owner_is_data_d;
         owner_is_write_q <= owner_is_write_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         rr_ptr_q         <= rr_ptr_d;
`endif
      end
   end
endmodule
